// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl: control-flow sequencer driving registered PC-bank strobes
// from next/jump/branch/call/return requests, with shadow call depth and sticky fault.
module pc_flow_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_op,
    input  logic [ADDR_W-1:0]         req_target,
    input  logic                      req_cond,
    output logic                      pc_inc,
    output logic                      pc_ref_inc,
    output logic                      pc_ref_dec,
    output logic                      pc_set,
    output logic [ADDR_W-1:0]         pc_set_value,
    output logic [$clog2(DEPTH)-1:0]  depth,
    output logic                      busy,
    output logic                      fault
);
    localparam int DW = $clog2(DEPTH);
    localparam logic [2:0] OP_NEXT = 3'd0, OP_JUMP = 3'd1, OP_BRANCH = 3'd2,
                           OP_CALL = 3'd3, OP_RET = 3'd4;
    typedef enum logic [1:0] {IDLE, CALL_SET, FAULT} state_t;
    state_t              state_q, state_d;
    logic [DW-1:0]       depth_q, depth_d;
    logic                fault_q, fault_d;
    logic [ADDR_W-1:0]   tgt_q, tgt_d;
    logic [ADDR_W-1:0]   val_q, val_d;
    logic                inc_q, inc_d, rinc_q, rinc_d, rdec_q, rdec_d, set_q, set_d;
    logic                accept;
    assign req_ready    = (state_q == IDLE) & ~fault_q;
    assign accept       = req_valid & req_ready;
    assign pc_inc       = inc_q;
    assign pc_ref_inc   = rinc_q;
    assign pc_ref_dec   = rdec_q;
    assign pc_set       = set_q;
    assign pc_set_value = val_q;
    assign depth        = depth_q;
    assign busy         = state_q == CALL_SET;
    assign fault        = fault_q;
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        fault_d = fault_q;
        tgt_d   = tgt_q;
        val_d   = val_q;
        inc_d   = 1'b0;
        rinc_d  = 1'b0;
        rdec_d  = 1'b0;
        set_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (req_op)
                        OP_NEXT: inc_d = 1'b1;
                        OP_JUMP: begin
                            set_d = 1'b1;
                            val_d = req_target;
                        end
                        OP_BRANCH: begin
                            inc_d = ~req_cond;
                            set_d = req_cond;
                            val_d = req_cond ? req_target : val_q;
                        end
                        OP_CALL: begin
                            if (depth_q == DW'(DEPTH - 1)) begin
                                fault_d = 1'b1;
                                state_d = FAULT;
                            end else begin
                                // caller frame advances past the call before the push
                                inc_d   = 1'b1;
                                rinc_d  = 1'b1;
                                tgt_d   = req_target;
                                depth_d = depth_q + DW'(1);
                                state_d = CALL_SET;
                            end
                        end
                        OP_RET: begin
                            if (depth_q == '0) begin
                                fault_d = 1'b1;
                                state_d = FAULT;
                            end else begin
                                rdec_d  = 1'b1;
                                depth_d = depth_q - DW'(1);
                            end
                        end
                        default: begin
                            fault_d = 1'b1;
                            state_d = FAULT;
                        end
                    endcase
                end
            end
            CALL_SET: begin
                set_d   = 1'b1;
                val_d   = tgt_q;
                state_d = IDLE;
            end
            default: state_d = FAULT;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            depth_q <= '0;
            fault_q <= 1'b0;
            tgt_q   <= '0;
            val_q   <= '0;
            inc_q   <= 1'b0;
            rinc_q  <= 1'b0;
            rdec_q  <= 1'b0;
            set_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            fault_q <= fault_d;
            tgt_q   <= tgt_d;
            val_q   <= val_d;
            inc_q   <= inc_d;
            rinc_q  <= rinc_d;
            rdec_q  <= rdec_d;
            set_q   <= set_d;
        end
    end
endmodule

// File: tb/tb_pc_flow_ctrl.sv
// tb_pc_flow_ctrl: scoreboard bench; a frame/depth reference model predicts each strobe
// event and its cycle, and a negedge monitor pops and compares whatever the DUT emits.
module tb_pc_flow_ctrl;
    localparam int AW = 9;
    localparam int D  = 8;
    logic          clk = 0, rst = 0, req_valid = 0, req_cond = 0;
    logic [2:0]    req_op = 0;
    logic [AW-1:0] req_target = 0;
    logic          req_ready, pc_inc, pc_ref_inc, pc_ref_dec, pc_set, busy, fault;
    logic [AW-1:0] pc_set_value;
    logic [2:0]    depth;
    pc_flow_ctrl #(.ADDR_W(AW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_target(req_target), .req_cond(req_cond),
        .pc_inc(pc_inc), .pc_ref_inc(pc_ref_inc), .pc_ref_dec(pc_ref_dec),
        .pc_set(pc_set), .pc_set_value(pc_set_value), .depth(depth),
        .busy(busy), .fault(fault)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    typedef struct {
        int            c;
        bit            inc, rinc, rdec, set;
        logic [AW-1:0] val;
    } ev_t;
    ev_t           q[$];
    int            tests = 0, fails = 0;
    int            m_depth = 0;
    bit            m_fault = 0;
    logic [AW-1:0] m_val = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic push(input int c, input bit inc, input bit rinc, input bit rdec, input bit set,
                        input logic [AW-1:0] val);
        ev_t e;
        e.c = c; e.inc = inc; e.rinc = rinc; e.rdec = rdec; e.set = set; e.val = val;
        q.push_back(e);
    endtask
    // Reference: bank frame index plus last loaded PC value; strobes land a cycle after accept.
    task automatic model(input logic [2:0] op, input logic [AW-1:0] tgt, input bit cond,
                         input int c, output bit call);
        call = 0;
        if (op == 0 || (op == 2 && !cond)) push(c, 1, 0, 0, 0, m_val);
        else if (op == 1 || op == 2) begin
            m_val = tgt;
            push(c, 0, 0, 0, 1, m_val);
        end else if (op == 3) begin
            if (m_depth == D - 1) m_fault = 1;
            else begin
                push(c, 1, 1, 0, 0, m_val);
                m_val = tgt;
                push(c + 1, 0, 0, 0, 1, m_val);
                m_depth++;
                call = 1;
            end
        end else if (op == 4) begin
            if (m_depth == 0) m_fault = 1;
            else begin
                push(c, 0, 0, 1, 0, m_val);
                m_depth--;
            end
        end else m_fault = 1;
    endtask
    always @(negedge clk) begin
        if (rst) chk("strobe_in_reset", {pc_inc, pc_ref_inc, pc_ref_dec, pc_set}, 0);
        else begin
            while (q.size() != 0 && q[0].c < cyc) begin
                chk("missing_strobe_at_cycle", cyc, q[0].c);
                void'(q.pop_front());
            end
            if (pc_inc | pc_ref_inc | pc_ref_dec | pc_set) begin
                if (q.size() == 0 || q[0].c != cyc) chk("unexpected_strobe", {pc_inc, pc_ref_inc, pc_ref_dec, pc_set}, 0);
                else begin
                    ev_t e;
                    e = q.pop_front();
                    chk("strobes", {pc_inc, pc_ref_inc, pc_ref_dec, pc_set}, {e.inc, e.rinc, e.rdec, e.set});
                    chk("pc_set_value", pc_set_value, e.val);
                end
            end
            chk("ref_inc_dec_exclusive", pc_ref_inc & pc_ref_dec, 0);
            chk("set_inc_exclusive", pc_set & pc_inc, 0);
        end
    end
    task automatic send(input logic [2:0] op, input logic [AW-1:0] tgt, input bit cond);
        bit rdy, call;
        @(negedge clk);
        rdy = !m_fault;
        chk("req_ready", req_ready, rdy);
        chk("depth", depth, m_depth);
        chk("fault", fault, m_fault);
        chk("busy_idle", busy, 0);
        req_valid = 1; req_op = op; req_target = tgt; req_cond = cond;
        call = 0;
        if (rdy) model(op, tgt, cond, cyc + 1, call);
        @(posedge clk);
        #1;
        if (call) begin
            @(negedge clk);
            chk("req_ready_call_set", req_ready, 0);
            chk("busy_call_set", busy, 1);
            chk("depth_call_set", depth, m_depth);
            @(posedge clk);
            #1;
        end
        req_valid = 0;
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_op = 3'($urandom_range(0, 7));
            req_target = AW'($urandom);
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1;
        q.delete();
        m_depth = 0; m_fault = 0; m_val = 0;
        @(negedge clk);
        chk("rst_strobes", {pc_inc, pc_ref_inc, pc_ref_dec, pc_set}, 0);
        chk("rst_value", pc_set_value, 0);
        chk("rst_depth", depth, 0);
        chk("rst_fault", fault, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 0;
    endtask
    initial begin
        bit unused;
        int x;
        do_reset();
        repeat (3) send(0, 0, 0);
        send(1, 9'h1A5, 0);
        send(2, 9'h010, 0);
        send(2, 9'h033, 1);
        send(3, 9'h040, 0);
        send(4, 0, 0);
        send(0, 0, 0);
        do_reset();
        repeat (7) send(3, AW'($urandom), 0);
        send(3, 9'h0FF, 0);
        repeat (3) send(0, 0, 0);
        do_reset();
        send(4, 0, 0);
        send(0, 0, 0);
        do_reset();
        send(6, 0, 0);
        send(1, 9'h055, 0);
        do_reset();
        // reset arrives while the new frame load is still pending
        @(negedge clk);
        req_valid = 1; req_op = 3; req_target = 9'h123;
        model(3, 9'h123, 0, cyc + 1, unused);
        @(posedge clk);
        #1 req_valid = 0;
        do_reset();
        idle(2);
        send(0, 0, 0);
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < 40; i++) begin
                x = $urandom_range(0, 99);
                if (x < 20) send(0, AW'($urandom), 1'($urandom));
                else if (x < 35) send(1, AW'($urandom), 0);
                else if (x < 50) send(2, AW'($urandom), 1'($urandom));
                else if (x < 75) send(3, AW'($urandom), 0);
                else if (x < 98) send(4, AW'($urandom), 0);
                else send(3'(5 + $urandom_range(0, 2)), 0, 0);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        idle(3);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
